alu_bist_scheduler: RTL and testbench
=====================================

ALU_BIST_SCHEDULER -- requirements
Module: alu_bist_scheduler

Interface
REQ-001 Parameter NUM_PATTERNS, default 16: ALU test vectors applied per run (range 2..256).
REQ-002 Parameter IDLE_MIN, default 4: consecutive ALU-idle cycles required before BIST may take the ALU (range 1..15).
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 core_req_i  in  1  core needs the ALU this cycle; the core always has priority.
REQ-006 core_sleep_i  in  1  core sleeping; the ALU counts as idle whatever core_req_i is.
REQ-007 alu_result_i  in  32  ALU result, combinational from the operands driven by this block.
REQ-008 bist_active_o  out  1  ALU input mux select: 1 means BIST owns the ALU this cycle.
REQ-009 bist_operand_a_o / bist_operand_b_o  out  32 each  test operands; the ALU operator is forced to ADD externally.
REQ-010 paddr_i[4:2], psel_i, penable_i, pwrite_i, pwdata_i[31:0]  in  APB slave inputs.
REQ-011 prdata_o  out  32 / pready_o  out  1  APB read data / ready.
REQ-012 done_o  out  1  one-cycle pulse when a run completes.
REQ-013 error_irq_o  out  1  level interrupt: fail_sticky AND irq_en.

Function
REQ-014 The APB interface SHALL be zero-wait: pready_o tied to 1; writes commit when psel_i&penable_i&pwrite_i; prdata_o is combinational from paddr_i.
REQ-015 The register map SHALL be:
- 0x0 CTRL RW: [0] enable, [1] start (write-1 pulse, reads 0), [2] irq_en.
- 0x4 PERIOD RW: 32-bit run interval; 0 means manual start only.
- 0x8 GOLDEN RW: expected signature.
- 0xC STATUS: [0] busy RO, [1] pass RO, [2] fail_sticky W1C, [15:8] run_count RO (wraps 255->0).
- 0x10 SIGNATURE RO: last final signature.
- Unmapped offsets read 0; writes to them are ignored.
REQ-016 FSM states SHALL be IDLE, WAIT_WIN, APPLY, COMPARE; busy is 1 in any state other than IDLE.
REQ-017 IDLE: an interval counter clears on entry and increments each cycle while enable=1.
- Go to WAIT_WIN when PERIOD!=0 and counter==PERIOD-1.
- Also go to WAIT_WIN when start is written with enable=1.
- Start written in any other state is ignored.
REQ-018 On IDLE->WAIT_WIN, the block SHALL load LFSR=0xACE10001, MISR=0 and pattern index=0.
REQ-019 WAIT_WIN: an idle counter increments (saturating at 15) when core_req_i=0 or core_sleep_i=1, and clears otherwise.
- Go to APPLY when idle counter >= IDLE_MIN.
REQ-020 Operand outputs:
- bist_operand_a_o = LFSR.
- bist_operand_b_o = LFSR rotated left by 7.
REQ-021 bist_active_o SHALL equal (state==APPLY) AND NOT (core_req_i AND NOT core_sleep_i), combinationally.
REQ-022 In each APPLY cycle with bist_active_o=1, at the clock edge:
- MISR <= ({MISR[30:0],0} XOR (MISR[31] ? 0x04C11DB7 : 0)) XOR alu_result_i.
- LFSR advances one step (Galois, taps 0x80200003).
- Index increments.
REQ-023 APPLY with a core conflict (bist_active_o=0): LFSR, MISR and index are held, the idle counter clears, and the next state is WAIT_WIN. Progress is preserved.
REQ-024 APPLY moves to COMPARE after the capture where index==NUM_PATTERNS-1. Otherwise APPLY stays in APPLY.
REQ-025 COMPARE (1 cycle), then IDLE:
- SIGNATURE <= MISR.
- pass <= (MISR==GOLDEN); fail_sticky set if they differ.
- run_count increments; done_o=1.
REQ-026 GOLDEN is sampled at COMPARE. PERIOD and GOLDEN writes SHALL be accepted in any state.
REQ-027 enable cleared in a non-IDLE state: go to IDLE on the next edge, bist_active_o=0 from then on, no STATUS/SIGNATURE update, no done_o.
REQ-028 Same-cycle W1C of fail_sticky and a COMPARE mismatch: the set wins.

Reset
REQ-029 While rst_i=1 at an edge the block SHALL load these values:
- state=IDLE; all counters, LFSR, MISR and index = 0.
- CTRL, PERIOD, GOLDEN, STATUS, SIGNATURE = 0.
REQ-030 Output values after reset:
- bist_active_o=0, done_o=0, error_irq_o=0, pready_o=1.
- Operands 0 until the next run loads the LFSR.
REQ-031 Reset asserted mid-run SHALL abort the run with no status update.

Verification
REQ-032 Manual run: PERIOD=0, CTRL=0x1, start, core_req_i=0, GOLDEN=0 -> APPLY entered IDLE_MIN cycles after WAIT_WIN entry; 16 consecutive bist_active_o cycles; done_o pulse; fail_sticky=1; SIGNATURE=S recorded.
REQ-033 Pass run: GOLDEN=S, clear fail via W1C 0x4, start -> pass=1, fail_sticky=0, run_count=2, error_irq_o=0.
REQ-034 Preemption: assert core_req_i at pattern 5 for 3 cycles -> bist_active_o drops the same cycle; resumes IDLE_MIN idle cycles after core_req_i falls; SIGNATURE still equals S.
REQ-035 Periodic: PERIOD=100, CTRL=0x5, GOLDEN wrong -> WAIT_WIN 100 cycles after each IDLE entry; error_irq_o=1 after the first run; held by core_sleep_i=1 even with core_req_i=1.
REQ-036 Abort: write CTRL=0 at pattern 8 -> IDLE next cycle; no done_o; STATUS unchanged.
REQ-037 Mid-run synchronous reset -> all outputs at reset values the next cycle; busy=0; run_count=0.

Source files
------------

// File: rtl/alu_bist_scheduler.sv
// alu_bist_scheduler
//   Borrows the ALU during core-idle windows to run an LFSR-driven ADD test.
//   The ALU results are compacted into a MISR, and the signature is compared
//   against a golden value.
//   Runs start on a software trigger or on a programmable interval.
//   Control and status are exposed through a zero-wait APB register file.
// Ports
//   clk_i, rst_i                         clock, synchronous active-high reset
//   core_req_i, core_sleep_i             core ALU demand / core asleep
//   alu_result_i                         ALU result for the driven operands
//   bist_active_o                        ALU mux select (1 = BIST owns ALU)
//   bist_operand_a_o, bist_operand_b_o   test operands (ALU forced to ADD)
//   paddr_i, psel_i, penable_i,
//   pwrite_i, pwdata_i                   APB slave inputs
//   prdata_o, pready_o                   APB read data / ready
//   done_o                               one-cycle pulse after a completed run
//   error_irq_o                          fail_sticky AND irq_en
module alu_bist_scheduler #(
    parameter int unsigned NUM_PATTERNS = 16,
    parameter int unsigned IDLE_MIN     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_sleep_i,
    input  logic [31:0] alu_result_i,
    output logic        bist_active_o,
    output logic [31:0] bist_operand_a_o,
    output logic [31:0] bist_operand_b_o,
    input  logic [4:2]  paddr_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        done_o,
    output logic        error_irq_o
);

    typedef enum logic [1:0] {StIdle, StWaitWin, StApply, StCompare} state_e;

    localparam logic [31:0] LfsrSeed = 32'hACE1_0001;
    localparam logic [31:0] LfsrTaps = 32'h8020_0003;
    localparam logic [31:0] MisrPoly = 32'h04C1_1DB7;
    localparam logic [7:0]  LastIdx  = 8'(NUM_PATTERNS - 1);
    localparam logic [3:0]  IdleMin  = 4'(IDLE_MIN);

    state_e      state_q;
    logic        enable_q, irq_en_q, pass_q, fail_q, done_q;
    logic [31:0] period_q, golden_q, signature_q, int_cnt_q, lfsr_q, misr_q;
    logic [7:0]  run_count_q, idx_q;
    logic [3:0]  idle_cnt_q;

    logic        wr_en, ctrl_wr, enable_nxt, start_wr, core_busy, busy, period_hit;
    logic [3:0]  idle_cnt_d;
    logic [31:0] lfsr_d, misr_d;

    assign wr_en      = psel_i & penable_i & pwrite_i;
    assign ctrl_wr    = wr_en && (paddr_i == 3'd0);
    // Enable as it will be after this edge; lets a disabling write abort a run
    // on the very edge it commits, and a CTRL=enable|start write start a run.
    assign enable_nxt = ctrl_wr ? pwdata_i[0] : enable_q;
    assign start_wr   = ctrl_wr & pwdata_i[1];
    assign core_busy  = core_req_i & ~core_sleep_i;
    assign busy       = (state_q != StIdle);
    assign period_hit = enable_q && (period_q != 32'd0) && (int_cnt_q == period_q - 32'd1);

    assign bist_active_o    = (state_q == StApply) && !core_busy;
    assign bist_operand_a_o = lfsr_q;
    assign bist_operand_b_o = {lfsr_q[24:0], lfsr_q[31:25]};
    assign pready_o         = 1'b1;
    assign done_o           = done_q;
    assign error_irq_o      = fail_q & irq_en_q;

    // Idle counter next value in WAIT_WIN; saturates at 15.
    assign idle_cnt_d = core_busy ? 4'd0 : ((idle_cnt_q == 4'd15) ? 4'd15 : idle_cnt_q + 4'd1);
    assign lfsr_d     = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'd0);
    assign misr_d     = {misr_q[30:0], 1'b0} ^ (misr_q[31] ? MisrPoly : 32'd0) ^ alu_result_i;

    always_comb begin
        prdata_o = 32'd0;
        case (paddr_i)
            3'd0:    prdata_o = {29'd0, irq_en_q, 1'b0, enable_q};
            3'd1:    prdata_o = period_q;
            3'd2:    prdata_o = golden_q;
            3'd3:    prdata_o = {16'd0, run_count_q, 5'd0, fail_q, pass_q, busy};
            3'd4:    prdata_o = signature_q;
            default: prdata_o = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            enable_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            done_q      <= 1'b0;
            period_q    <= 32'd0;
            golden_q    <= 32'd0;
            signature_q <= 32'd0;
            int_cnt_q   <= 32'd0;
            lfsr_q      <= 32'd0;
            misr_q      <= 32'd0;
            run_count_q <= 8'd0;
            idx_q       <= 8'd0;
            idle_cnt_q  <= 4'd0;
        end else begin
            done_q <= 1'b0;
            if (ctrl_wr) begin
                enable_q <= pwdata_i[0];
                irq_en_q <= pwdata_i[2];
            end
            if (wr_en && (paddr_i == 3'd1)) period_q <= pwdata_i;
            if (wr_en && (paddr_i == 3'd2)) golden_q <= pwdata_i;
            // W1C first; a COMPARE mismatch below overrides it in the same edge.
            if (wr_en && (paddr_i == 3'd3) && pwdata_i[2]) fail_q <= 1'b0;

            if (state_q == StIdle) begin
                idle_cnt_q <= 4'd0;
                if (enable_nxt && (start_wr || period_hit)) begin
                    state_q   <= StWaitWin;
                    int_cnt_q <= 32'd0;
                    lfsr_q    <= LfsrSeed;
                    misr_q    <= 32'd0;
                    idx_q     <= 8'd0;
                end else if (enable_q) begin
                    int_cnt_q <= int_cnt_q + 32'd1;
                end
            end else begin
                int_cnt_q <= 32'd0;
                if (!enable_nxt) begin
                    // Abort: no capture, no status update, no done pulse.
                    state_q <= StIdle;
                end else begin
                    case (state_q)
                        StWaitWin: begin
                            idle_cnt_q <= idle_cnt_d;
                            if (idle_cnt_d >= IdleMin) state_q <= StApply;
                        end
                        StApply: begin
                            if (bist_active_o) begin
                                misr_q <= misr_d;
                                lfsr_q <= lfsr_d;
                                idx_q  <= idx_q + 8'd1;
                                if (idx_q == LastIdx) state_q <= StCompare;
                            end else begin
                                // Core preempted: keep progress, wait for a new window.
                                idle_cnt_q <= 4'd0;
                                state_q    <= StWaitWin;
                            end
                        end
                        StCompare: begin
                            signature_q <= misr_q;
                            pass_q      <= (misr_q == golden_q);
                            if (misr_q != golden_q) fail_q <= 1'b1;
                            run_count_q <= run_count_q + 8'd1;
                            done_q      <= 1'b1;
                            state_q     <= StIdle;
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_bist_scheduler.sv
// Directed bench for alu_bist_scheduler: manual, pass, preemption, abort,
// periodic and mid-run reset scenarios against hand values and a small model.
module tb_alu_bist_scheduler;

    localparam int NP = 16;
    localparam int IM = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_req_i = 1'b0;
    logic        core_sleep_i = 1'b0;
    logic [31:0] alu_result_i;
    logic        bist_active_o;
    logic [31:0] bist_operand_a_o, bist_operand_b_o;
    logic [4:2]  paddr_i = 3'd0;
    logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
    logic [31:0] pwdata_i = 32'd0;
    logic [31:0] prdata_o;
    logic        pready_o, done_o, error_irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // External ALU, operator forced to ADD.
    assign alu_result_i = bist_operand_a_o + bist_operand_b_o;

    alu_bist_scheduler #(.NUM_PATTERNS(NP), .IDLE_MIN(IM)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .core_req_i      (core_req_i),
        .core_sleep_i    (core_sleep_i),
        .alu_result_i    (alu_result_i),
        .bist_active_o   (bist_active_o),
        .bist_operand_a_o(bist_operand_a_o),
        .bist_operand_b_o(bist_operand_b_o),
        .paddr_i         (paddr_i),
        .psel_i          (psel_i),
        .penable_i       (penable_i),
        .pwrite_i        (pwrite_i),
        .pwdata_i        (pwdata_i),
        .prdata_o        (prdata_o),
        .pready_o        (pready_o),
        .done_o          (done_o),
        .error_irq_o     (error_irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Two-phase APB write; returns on the falling edge after the commit edge.
    task automatic apb_write(input logic [2:0] a, input logic [31:0] d);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d;
        @(negedge clk);
        penable_i = 1'b1;
        @(negedge clk);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] a, output logic [31:0] d);
        paddr_i = a;
        #1;
        d = prdata_o;
    endtask

    task automatic wait_active(output int n);
        n = 0;
        forever begin
            #1;
            if (bist_active_o || n >= 300) break;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        forever begin
            #1;
            if (done_o || n >= 300) break;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        forever begin
            paddr_i = 3'd3;
            #1;
            if (prdata_o[0] || n >= 300) break;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_active(output int n);
        n = 0;
        while (bist_active_o && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] model_sig();
        logic [31:0] l, m;
        l = 32'hACE1_0001;
        m = 32'd0;
        for (int i = 0; i < NP; i++) begin
            m = {m[30:0], 1'b0} ^ (m[31] ? 32'h04C1_1DB7 : 32'd0) ^ (l + {l[24:0], l[31:25]});
            l = {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'd0);
        end
        return m;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, sig;
        int n, ndone;
        sig = model_sig();

        // Reset state and unmapped offsets
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rst_active", 32'(bist_active_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_irq", 32'(error_irq_o), 32'd0);
        check("rst_pready", 32'(pready_o), 32'd1);
        check("rst_op_a", bist_operand_a_o, 32'd0);
        check("rst_op_b", bist_operand_b_o, 32'd0);
        apb_read(3'd3, rd); check("rst_status", rd, 32'd0);
        apb_read(3'd4, rd); check("rst_sig", rd, 32'd0);
        apb_write(3'd5, 32'hFFFF_FFFF);
        apb_read(3'd5, rd); check("unmapped5", rd, 32'd0);
        apb_read(3'd7, rd); check("unmapped7", rd, 32'd0);
        apb_read(3'd0, rd); check("ctrl_after_unmapped", rd, 32'd0);

        // Manual run with GOLDEN=0: expected to fail
        apb_write(3'd1, 32'd0);
        apb_write(3'd2, 32'd0);
        apb_write(3'd0, 32'h1);
        apb_write(3'd0, 32'h3);
        wait_active(n);
        check("m_win_latency", 32'(n), 32'(IM));
        check("m_op_a0", bist_operand_a_o, 32'hACE1_0001);
        check("m_op_b0", bist_operand_b_o, 32'h7080_00D6);
        count_active(n);
        check("m_active_len", 32'(n), 32'(NP));
        check("m_done_compare", 32'(done_o), 32'd0);
        @(negedge clk); #1;
        check("m_done_pulse", 32'(done_o), 32'd1);
        @(negedge clk); #1;
        check("m_done_width", 32'(done_o), 32'd0);
        apb_read(3'd3, rd); check("m_status", rd, 32'h0000_0104);
        apb_read(3'd4, rd); check("m_signature", rd, sig);
        apb_read(3'd0, rd); check("m_ctrl_start_reads0", rd, 32'h1);

        // Pass run after W1C
        apb_write(3'd2, sig);
        apb_write(3'd3, 32'h4);
        apb_read(3'd3, rd); check("p_w1c", rd, 32'h0000_0100);
        apb_write(3'd0, 32'h3);
        wait_done(n);
        check("p_done_seen", 32'(done_o), 32'd1);
        apb_read(3'd3, rd); check("p_status", rd, 32'h0000_0202);
        check("p_irq", 32'(error_irq_o), 32'd0);

        // Preemption at pattern 5 for 3 cycles
        apb_write(3'd0, 32'h3);
        wait_active(n);
        check("pr_win_latency", 32'(n), 32'(IM));
        @(negedge clk); #1;
        check("pr_op_a1", bist_operand_a_o, 32'hD650_8003);
        repeat (4) @(negedge clk);
        core_req_i = 1'b1;
        #1;
        check("pr_drop_same_cycle", 32'(bist_active_o), 32'd0);
        repeat (3) @(negedge clk);
        core_req_i = 1'b0;
        wait_active(n);
        check("pr_resume_latency", 32'(n), 32'(IM));
        count_active(n);
        check("pr_remaining", 32'(n), 32'(NP - 5));
        wait_done(n);
        check("pr_done_seen", 32'(done_o), 32'd1);
        apb_read(3'd4, rd); check("pr_signature", rd, sig);
        apb_read(3'd3, rd); check("pr_status", rd, 32'h0000_0302);

        // Abort by clearing enable mid-run
        apb_write(3'd0, 32'h3);
        wait_active(n);
        repeat (8) @(negedge clk);
        apb_write(3'd0, 32'h0);
        #1;
        check("ab_active", 32'(bist_active_o), 32'd0);
        apb_read(3'd3, rd); check("ab_status", rd, 32'h0000_0302);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (done_o) ndone++;
        end
        check("ab_no_done", 32'(ndone), 32'd0);
        apb_read(3'd4, rd); check("ab_signature", rd, sig);

        // Periodic runs with wrong golden; W1C lands on the COMPARE edge
        apb_write(3'd2, sig ^ 32'h1);
        apb_write(3'd1, 32'd100);
        apb_write(3'd0, 32'h5);
        wait_busy(n);
        check("pe_period1", 32'(n), 32'd100);
        wait_active(n);
        check("pe_win1", 32'(n), 32'(IM));
        repeat (NP - 1) @(negedge clk);
        #1;
        check("pe_last_active", 32'(bist_active_o), 32'd1);
        apb_write(3'd3, 32'h4);
        #1;
        check("pe_done1", 32'(done_o), 32'd1);
        check("pe_irq1", 32'(error_irq_o), 32'd1);
        apb_read(3'd3, rd); check("pe_set_wins", rd, 32'h0000_0404);
        core_req_i = 1'b1;
        core_sleep_i = 1'b1;
        wait_busy(n);
        check("pe_period2", 32'(n), 32'd100);
        wait_active(n);
        check("pe_win_sleep", 32'(n), 32'(IM));
        count_active(n);
        check("pe_active_sleep", 32'(n), 32'(NP));
        wait_done(n);
        check("pe_done2", 32'(done_o), 32'd1);
        check("pe_irq2", 32'(error_irq_o), 32'd1);
        apb_read(3'd3, rd); check("pe_status2", rd, 32'h0000_0504);
        core_req_i = 1'b0;
        core_sleep_i = 1'b0;

        // Mid-run synchronous reset
        apb_write(3'd0, 32'h3);
        #1;
        check("rs_irq_masked", 32'(error_irq_o), 32'd0);
        wait_active(n);
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rs_active", 32'(bist_active_o), 32'd0);
        check("rs_done", 32'(done_o), 32'd0);
        check("rs_irq", 32'(error_irq_o), 32'd0);
        check("rs_pready", 32'(pready_o), 32'd1);
        check("rs_op_a", bist_operand_a_o, 32'd0);
        check("rs_op_b", bist_operand_b_o, 32'd0);
        apb_read(3'd3, rd); check("rs_status", rd, 32'd0);
        apb_read(3'd0, rd); check("rs_ctrl", rd, 32'd0);
        apb_read(3'd1, rd); check("rs_period", rd, 32'd0);
        apb_read(3'd2, rd); check("rs_golden", rd, 32'd0);
        apb_read(3'd4, rd); check("rs_sig", rd, 32'd0);
        repeat (5) @(negedge clk);
        apb_read(3'd3, rd); check("rs_stays_idle", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
